// File: rtl/key_pulse_pkg.sv
// Shared types for the mode-button conditioner: FSM state encodings and a counter-fit helper.
package key_pulse_pkg;

    typedef enum logic [1:0] {
        K_IDLE         = 2'd0,
        K_PRESS_WAIT   = 2'd1,
        K_PRESSED      = 2'd2,
        K_RELEASE_WAIT = 2'd3
    } key_state_e;

    // True when a terminal count fits in an unsigned counter of width w.
    function automatic bit cnt_fits(input longint val, input int w);
        return (val >= 1) && (val < (longint'(1) << w));
    endfunction

endpackage

// File: rtl/key_sync.sv
// N-flop level synchroniser with synchronous active-high reset to 0.
module key_sync #(
    parameter int N = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    if (N < 2) begin : g_chk_n
        $error("key_sync: N must be at least 2");
    end

    logic [N-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) sync_q <= '0;
        else       sync_q <= {sync_q[N-2:0], d_i};
    end

    assign q_o = sync_q[N-1];

endmodule

// File: rtl/key_pulse.sv
// Mode-button conditioner: sync, debounce, one state_change pulse per accepted press.
// Optional long-press pulse enabled by defining LONG_PRESS_EN.
module key_pulse
    import key_pulse_pkg::*;
#(
    parameter int   CNT_W           = 26,
    parameter int   DEBOUNCE_CYCLES = 1_000_000,
    parameter int   LONG_CYCLES     = 50_000_000,
    parameter logic BTN_ACTIVE      = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic state_change,
    output logic btn_level,
    output logic long_press
);

    if (!cnt_fits(longint'(DEBOUNCE_CYCLES), CNT_W)) begin : g_chk_deb
        $error("key_pulse: DEBOUNCE_CYCLES must be in [1, 2**CNT_W)");
    end
    if (!cnt_fits(longint'(LONG_CYCLES), CNT_W)) begin : g_chk_long
        $error("key_pulse: LONG_CYCLES must be in [1, 2**CNT_W)");
    end

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_DONE = CNT_W'(LONG_CYCLES);
`endif

    logic btn_in;
    logic btn_s;

    // Normalise polarity before synchronising so the FSM always sees 1 = pressed.
    assign btn_in = btn_raw ~^ BTN_ACTIVE;

    key_sync #(.N(2)) u_sync (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (btn_in),
        .q_o   (btn_s)
    );

    key_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             state_change_q;
    logic             btn_level_q;
    logic             long_press_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= K_RELEASE_WAIT;
            cnt_q          <= '0;
            state_change_q <= 1'b0;
            btn_level_q    <= 1'b0;
            long_press_q   <= 1'b0;
        end else begin
            state_change_q <= 1'b0;
            long_press_q   <= 1'b0;
            case (state_q)
                K_IDLE: begin
                    if (btn_s) begin
                        state_q <= K_PRESS_WAIT;
                        cnt_q   <= '0;
                    end
                end
                K_PRESS_WAIT: begin
                    if (!btn_s) begin
                        state_q <= K_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_q        <= K_PRESSED;
                        state_change_q <= 1'b1;
                        btn_level_q    <= 1'b1;
                        cnt_q          <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                K_PRESSED: begin
                    if (!btn_s) begin
                        state_q <= K_RELEASE_WAIT;
                        cnt_q   <= '0;
                    end else begin
`ifdef LONG_PRESS_EN
                        // Parking at LONG_DONE makes the pulse one-shot per press.
                        if (cnt_q == LONG_LAST) begin
                            long_press_q <= 1'b1;
                            cnt_q        <= LONG_DONE;
                        end else if (cnt_q < LONG_LAST) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
`else
                        cnt_q <= '0;
`endif
                    end
                end
                K_RELEASE_WAIT: begin
                    // A re-press before release is confirmed is a bounce, not a new press.
                    if (btn_s) begin
                        state_q <= K_PRESSED;
                        cnt_q   <= '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_q     <= K_IDLE;
                        btn_level_q <= 1'b0;
                        cnt_q       <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= K_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign state_change = state_change_q;
    assign btn_level    = btn_level_q;
`ifdef LONG_PRESS_EN
    assign long_press   = long_press_q;
`else
    assign long_press   = 1'b0;
`endif

endmodule
